// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - register-file write hazard scoreboard with drain handshake
module wb_scoreboard #(
    parameter int CNT_W             = 2,
    parameter bit REGS_PASS_THROUGH = 1'b1,
    parameter int TOT_W             = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_iss_valid,
    input  logic             i_iss_wr,
    input  logic [4:0]       i_iss_rd,
    input  logic             i_iss_use_rs1,
    input  logic             i_iss_use_rs2,
    input  logic [4:0]       i_iss_rs1,
    input  logic [4:0]       i_iss_rs2,
    output logic             o_iss_ready,
    output logic             o_hz_data,
    input  logic             i_wb_valid,
    input  logic [4:0]       i_wb_rd,
    input  logic             i_flush,
    input  logic             i_drain_req,
    output logic             o_drained,
    output logic [TOT_W-1:0] o_inflight,
    output logic             o_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt [32];
    logic [TOT_W-1:0] inflight_next;

    logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
    logic             hz_rs1, hz_rs2, sat, fire;
    logic             inc, wb_eff, same, up, down;
    logic             underflow, overflow;

    // Source hazards, saturation stall and the issue/writeback pairing terms.
    always_comb begin
        cnt_rs1 = cnt[i_iss_rs1];
        cnt_rs2 = cnt[i_iss_rs2];
        cnt_rd  = cnt[i_iss_rd];
        cnt_wb  = cnt[i_wb_rd];
        // A register whose last pending write retires this cycle is already safe to read.
        hz_rs1 = i_iss_use_rs1 && (i_iss_rs1 != 5'd0) && (cnt_rs1 != '0) &&
                 !(REGS_PASS_THROUGH && (cnt_rs1 == CNT_ONE) && i_wb_valid && (i_wb_rd == i_iss_rs1));
        hz_rs2 = i_iss_use_rs2 && (i_iss_rs2 != 5'd0) && (cnt_rs2 != '0) &&
                 !(REGS_PASS_THROUGH && (cnt_rs2 == CNT_ONE) && i_wb_valid && (i_wb_rd == i_iss_rs2));
        sat = i_iss_wr && (i_iss_rd != 5'd0) && (cnt_rd == CNT_MAX) &&
              !(i_wb_valid && (i_wb_rd == i_iss_rd));
        fire      = i_iss_valid && o_iss_ready;
        inc       = fire && i_iss_wr && (i_iss_rd != 5'd0);
        wb_eff    = i_wb_valid && (i_wb_rd != 5'd0);
        // Issue and writeback on the same register cancel each other out.
        same      = inc && wb_eff && (i_iss_rd == i_wb_rd);
        up        = inc && !same;
        down      = wb_eff && !same && (cnt_wb != '0);
        underflow = wb_eff && !same && (cnt_wb == '0);
        overflow  = up && (cnt_rd == CNT_MAX);
        if (i_flush) begin
            inflight_next = '0;
        end else begin
            inflight_next = o_inflight + TOT_W'(up) - TOT_W'(down);
        end
    end

    // Per-register pending counters; x0 never moves because inc/wb_eff exclude it.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 32; i++) begin
            if (!i_rst_n || i_flush) begin
                cnt[i] <= '0;
            end else if (up && (i_iss_rd == 5'(i))) begin
                cnt[i] <= cnt[i] + CNT_ONE;
            end else if (down && (i_wb_rd == 5'(i))) begin
                cnt[i] <= cnt[i] - CNT_ONE;
            end
        end
    end

    // Total outstanding writes and the sticky error flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_inflight <= '0;
            o_err      <= 1'b0;
        end else begin
            o_inflight <= inflight_next;
            if (!i_flush && (underflow || overflow)) begin
                o_err <= 1'b1;
            end
        end
    end

    // Drain FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Drain FSM next state.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (i_drain_req) state_next = DRAIN;
            DRAIN:   if (inflight_next == '0) state_next = DONE;
            DONE:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Drain FSM outputs and issue gating.
    always_comb begin
        o_drained   = (state == DONE);
        o_hz_data   = i_iss_valid && (hz_rs1 || hz_rs2);
        o_iss_ready = (state == RUN) && !o_hz_data && !sat && !i_flush;
    end

endmodule
